// File: rtl/rob_pkg.sv
// Reorder buffer shared types: sizes, tag/count types, entry layout.
// Pointer helper adds a slot offset to a ROB tag, wrapping modulo ROB_SIZE.
package rob_pkg;
  localparam int ROB_SIZE  = 32;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int ARCH_REGS = 32;
  localparam int REG_IDX_W = $clog2(ARCH_REGS);
  localparam int XLEN      = 32;

  typedef logic [ROB_IDX_W-1:0] rob_tag_t;
  typedef logic [ROB_IDX_W:0]   rob_cnt_t;

  typedef struct packed {
    logic                 valid;
    logic                 complete;
    logic                 has_dest;
    logic [REG_IDX_W-1:0] dest;
    logic [XLEN-1:0]      value;
  } rob_entry_t;

  function automatic rob_tag_t rob_add(
    input rob_tag_t   p,
    input logic [1:0] n
  );
    return p + rob_tag_t'(n);
  endfunction
endpackage

// File: rtl/rob_retire_select.sv
// Retire width select: counts consecutive ready entries from the head.
// Ports: head_rdy_i[i] = valid&complete of head+i; retire_num_o = 0..3.
module rob_retire_select
  import rob_pkg::*;
(
  input  logic [2:0] head_rdy_i,
  output logic [1:0] retire_num_o
);
  always_comb begin
    retire_num_o = 2'd0;
    if (!head_rdy_i[0])      retire_num_o = 2'd0;
    else if (!head_rdy_i[1]) retire_num_o = 2'd1;
    else if (!head_rdy_i[2]) retire_num_o = 2'd2;
    else                     retire_num_o = 2'd3;
  end
endmodule

// File: rtl/rob_core.sv
// 3-wide reorder buffer: in-order allocate, CDB capture, in-order retire.
// Ports: dispatch_*, complete/CDB_*, retire_*, rob_empty/full.
// Optional squash port and flush behaviour under `ROB_SQUASH_EN.
module rob_core
  import rob_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     dispatch_num,
  input  logic [2:0][REG_IDX_W-1:0]      dispatch_dest_idx,
  input  logic [2:0]                     dispatch_has_dest,
  output logic [ROB_IDX_W-1:0]           rob_tail_out,
  output logic [1:0]                     dispatch_avail,
  input  logic [1:0]                     complete_num,
  input  logic [2:0][ROB_IDX_W-1:0]      CDB_tag_in,
  input  logic [2:0][XLEN-1:0]           CDB_value_in,
  output logic [1:0]                     retire_num,
  output logic [2:0][ROB_IDX_W-1:0]      retire_tag,
  output logic [2:0][REG_IDX_W-1:0]      retire_dest_idx,
  output logic [2:0]                     retire_has_dest,
  output logic [2:0][XLEN-1:0]           retire_value,
  output logic                           rob_empty,
  output logic                           rob_full
`ifdef ROB_SQUASH_EN
  ,
  input  logic                           squash
`endif
);
  rob_entry_t ent_q [ROB_SIZE];
  rob_entry_t ent_d [ROB_SIZE];
  rob_tag_t   head_q, head_d;
  rob_tag_t   tail_q, tail_d;
  rob_cnt_t   cnt_q, cnt_d;

  logic       squash_w;
  logic [2:0] head_rdy;
  logic [1:0] ret_sel;
  rob_cnt_t   free;
  logic       accept;
  logic [1:0] disp_acc;

`ifdef ROB_SQUASH_EN
  assign squash_w = squash;
`else
  assign squash_w = 1'b0;
`endif

  always_comb begin
    head_rdy = '0;
    for (int i = 0; i < 3; i++) begin
      head_rdy[i] = ent_q[rob_add(head_q, 2'(i))].valid
                  & ent_q[rob_add(head_q, 2'(i))].complete;
    end
  end

  rob_retire_select u_sel (
    .head_rdy_i   (head_rdy),
    .retire_num_o (ret_sel)
  );

  assign retire_num = squash_w ? 2'd0 : ret_sel;

  // Availability reflects only the registered count.
  assign free           = rob_cnt_t'(ROB_SIZE) - cnt_q;
  assign dispatch_avail = (free >= rob_cnt_t'(3)) ? 2'd3 : free[1:0];
  assign accept         = (dispatch_num <= dispatch_avail) && !squash_w;
  assign disp_acc       = accept ? dispatch_num : 2'd0;

  assign rob_tail_out = tail_q + rob_tag_t'(dispatch_num) - rob_tag_t'(1);
  assign rob_empty    = (cnt_q == '0);
  assign rob_full     = (cnt_q == rob_cnt_t'(ROB_SIZE));

  always_comb begin
    retire_tag      = '0;
    retire_dest_idx = '0;
    retire_has_dest = '0;
    retire_value    = '0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < retire_num) begin
        retire_tag[i]      = rob_add(head_q, 2'(i));
        retire_dest_idx[i] = ent_q[rob_add(head_q, 2'(i))].dest;
        retire_has_dest[i] = ent_q[rob_add(head_q, 2'(i))].has_dest;
        retire_value[i]    = ent_q[rob_add(head_q, 2'(i))].value;
      end
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q + rob_tag_t'(retire_num);
    tail_d = tail_q + rob_tag_t'(disp_acc);
    cnt_d  = cnt_q + rob_cnt_t'(disp_acc) - rob_cnt_t'(retire_num);
    // Later slot overwrites earlier on duplicate tags.
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < complete_num && ent_q[CDB_tag_in[i]].valid) begin
        ent_d[CDB_tag_in[i]].complete = 1'b1;
        ent_d[CDB_tag_in[i]].value    = CDB_value_in[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < retire_num) begin
        ent_d[rob_add(head_q, 2'(i))].valid    = 1'b0;
        ent_d[rob_add(head_q, 2'(i))].complete = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < disp_acc) begin
        ent_d[rob_add(tail_q, 2'(i))].valid    = 1'b1;
        ent_d[rob_add(tail_q, 2'(i))].complete = 1'b0;
        ent_d[rob_add(tail_q, 2'(i))].has_dest = dispatch_has_dest[i];
        ent_d[rob_add(tail_q, 2'(i))].dest     = dispatch_dest_idx[i];
        ent_d[rob_add(tail_q, 2'(i))].value    = '0;
      end
    end
    if (squash_w) begin
      for (int j = 0; j < ROB_SIZE; j++) begin
        ent_d[j].valid    = 1'b0;
        ent_d[j].complete = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < ROB_SIZE; j++) ent_q[j] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int j = 0; j < ROB_SIZE; j++) ent_q[j] <= ent_d[j];
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Oversized dispatch groups are an upstream bug; the group is dropped.
  always @(posedge clk) begin
    if (reset && !squash_w) begin
      assert (dispatch_num <= dispatch_avail)
        else $warning("rob_core: dispatch_num %0d > avail %0d, group dropped",
                      dispatch_num, dispatch_avail);
    end
  end
`endif
endmodule

// File: tb/tb_rob_core.sv
// Self-checking bench for rob_core against a program-order queue model.
// Directed scenarios plus randomized dispatch/complete traffic.
module tb_rob_core;
  import rob_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [1:0]                dispatch_num;
  logic [2:0][REG_IDX_W-1:0] dispatch_dest_idx;
  logic [2:0]                dispatch_has_dest;
  logic [ROB_IDX_W-1:0]      rob_tail_out;
  logic [1:0]                dispatch_avail;
  logic [1:0]                complete_num;
  logic [2:0][ROB_IDX_W-1:0] CDB_tag_in;
  logic [2:0][XLEN-1:0]      CDB_value_in;
  logic [1:0]                retire_num;
  logic [2:0][ROB_IDX_W-1:0] retire_tag;
  logic [2:0][REG_IDX_W-1:0] retire_dest_idx;
  logic [2:0]                retire_has_dest;
  logic [2:0][XLEN-1:0]      retire_value;
  logic                      rob_empty;
  logic                      rob_full;
`ifdef ROB_SQUASH_EN
  logic                      squash;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_core dut (
    .clk               (clk),
    .reset             (reset),
    .dispatch_num      (dispatch_num),
    .dispatch_dest_idx (dispatch_dest_idx),
    .dispatch_has_dest (dispatch_has_dest),
    .rob_tail_out      (rob_tail_out),
    .dispatch_avail    (dispatch_avail),
    .complete_num      (complete_num),
    .CDB_tag_in        (CDB_tag_in),
    .CDB_value_in      (CDB_value_in),
    .retire_num        (retire_num),
    .retire_tag        (retire_tag),
    .retire_dest_idx   (retire_dest_idx),
    .retire_has_dest   (retire_has_dest),
    .retire_value      (retire_value),
    .rob_empty         (rob_empty),
    .rob_full          (rob_full)
`ifdef ROB_SQUASH_EN
    ,
    .squash            (squash)
`endif
  );

  // Reference model: live instructions in program order.
  typedef struct {
    int          tag;
    int          dest;
    bit          hd;
    bit          done;
    logic [31:0] val;
  } ment_t;

  ment_t mq[$];
  int    m_tail = 0;

  function automatic int m_avail();
    int f;
    f = ROB_SIZE - mq.size();
    return (f > 3) ? 3 : f;
  endfunction

  function automatic int m_retn();
    int n;
    n = 0;
    while (n < 3 && n < mq.size() && mq[n].done) n++;
`ifdef ROB_SQUASH_EN
    if (squash) n = 0;
`endif
    return n;
  endfunction

  task automatic model_edge();
    int    rn;
    bit    acc;
    ment_t e;
    rn  = m_retn();
    acc = int'(dispatch_num) <= m_avail();
`ifdef ROB_SQUASH_EN
    if (squash) begin
      mq.delete();
      m_tail = 0;
      return;
    end
`endif
    for (int i = 0; i < int'(complete_num); i++) begin
      foreach (mq[k]) begin
        if (mq[k].tag == int'(CDB_tag_in[i])) begin
          mq[k].done = 1'b1;
          mq[k].val  = CDB_value_in[i];
        end
      end
    end
    repeat (rn) void'(mq.pop_front());
    if (acc) begin
      for (int i = 0; i < int'(dispatch_num); i++) begin
        e.tag  = m_tail;
        e.dest = int'(dispatch_dest_idx[i]);
        e.hd   = dispatch_has_dest[i];
        e.done = 1'b0;
        e.val  = '0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % ROB_SIZE;
      end
    end
  endtask

  task automatic idle();
    dispatch_num      = '0;
    dispatch_dest_idx = '0;
    dispatch_has_dest = '0;
    complete_num      = '0;
    CDB_tag_in        = '0;
    CDB_value_in      = '0;
`ifdef ROB_SQUASH_EN
    squash            = 1'b0;
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    mq.delete();
    m_tail = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic rand_dests(input int n);
    for (int i = 0; i < 3; i++) begin
      dispatch_dest_idx[i] = REG_IDX_W'($urandom_range(ARCH_REGS - 1));
      dispatch_has_dest[i] = 1'($urandom_range(1));
    end
    dispatch_num = 2'(n);
  endtask

  task automatic fill_to(input int n);
    int k;
    while (mq.size() < n) begin
      k = n - mq.size();
      if (k > m_avail()) k = m_avail();
      rand_dests(k);
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) begin
      rand_dests(2);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rob_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_empty got=%b exp=1", rob_empty);
    end
    mq.delete();
    m_tail = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (rob_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty got=%b exp=1", rob_empty);
    end
    checks++;
    if (dispatch_avail !== 2'd3) begin
      errors++;
      $display("FAIL reset_avail got=%0d exp=3", dispatch_avail);
    end
    checks++;
    if (retire_num !== 2'd0) begin
      errors++;
      $display("FAIL reset_retire got=%0d exp=0", retire_num);
    end
    checks++;
    if (rob_tail_out !== 5'd31) begin
      errors++;
      $display("FAIL reset_tail got=%0d exp=31", rob_tail_out);
    end
    checks++;
    if (rob_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full got=%b exp=0", rob_full);
    end
  endtask

  task automatic test_dispatch();
    do_reset();
    repeat (5) begin
      rand_dests(1);
      tick();
    end
    dispatch_num         = 2'd2;
    dispatch_dest_idx[0] = 5'd1;
    dispatch_dest_idx[1] = 5'd2;
    dispatch_has_dest    = 3'b011;
    #1;
    checks++;
    if (rob_tail_out !== 5'd6) begin
      errors++;
      $display("FAIL disp_tail_same got=%0d exp=6", rob_tail_out);
    end
    tick();
    #1;
    checks++;
    if (rob_tail_out !== 5'd6) begin
      errors++;
      $display("FAIL disp_tail_next got=%0d exp=6", rob_tail_out);
    end
    checks++;
    if (rob_empty !== 1'b0 || dispatch_avail !== 2'd3) begin
      errors++;
      $display("FAIL disp_state got=%b/%0d exp=0/3", rob_empty, dispatch_avail);
    end
  endtask

  task automatic test_complete_retire();
    complete_num    = 2'd2;
    CDB_tag_in[0]   = 5'd1;
    CDB_value_in[0] = 32'hA;
    CDB_tag_in[1]   = 5'd0;
    CDB_value_in[1] = 32'hB;
    #1;
    checks++;
    if (retire_num !== 2'd0) begin
      errors++;
      $display("FAIL cr_same_cycle got=%0d exp=0", retire_num);
    end
    tick();
    #1;
    checks++;
    if (retire_num !== 2'd2) begin
      errors++;
      $display("FAIL cr_num got=%0d exp=2", retire_num);
    end
    checks++;
    if (retire_tag[0] !== 5'd0 || retire_tag[1] !== 5'd1) begin
      errors++;
      $display("FAIL cr_tags got=%0d,%0d exp=0,1", retire_tag[0], retire_tag[1]);
    end
    checks++;
    if (retire_value[0] !== 32'hB || retire_value[1] !== 32'hA) begin
      errors++;
      $display("FAIL cr_vals got=%h,%h exp=b,a", retire_value[0], retire_value[1]);
    end
    checks++;
    if (retire_tag[2] !== '0 || retire_value[2] !== '0) begin
      errors++;
      $display("FAIL cr_unused got=%0d,%h exp=0,0", retire_tag[2], retire_value[2]);
    end
    tick();
    complete_num    = 2'd1;
    CDB_tag_in[0]   = 5'd3;
    CDB_value_in[0] = 32'h33;
    tick();
    #1;
    checks++;
    if (retire_num !== 2'd0) begin
      errors++;
      $display("FAIL cr_gap got=%0d exp=0", retire_num);
    end
    complete_num    = 2'd2;
    CDB_tag_in[0]   = 5'd2;
    CDB_value_in[0] = 32'h22;
    CDB_tag_in[1]   = 5'd6;
    CDB_value_in[1] = 32'h66;
    tick();
    complete_num    = 2'd3;
    CDB_tag_in[0]   = 5'd5;
    CDB_value_in[0] = 32'h11;
    CDB_tag_in[1]   = 5'd4;
    CDB_value_in[1] = 32'h44;
    CDB_tag_in[2]   = 5'd5;
    CDB_value_in[2] = 32'h55;
    #1;
    checks++;
    if (retire_num !== 2'd2 || retire_tag[0] !== 5'd2) begin
      errors++;
      $display("FAIL cr_two got=%0d/%0d exp=2/2", retire_num, retire_tag[0]);
    end
    tick();
    #1;
    checks++;
    if (retire_num !== 2'd3 || retire_tag[2] !== 5'd6) begin
      errors++;
      $display("FAIL cr_three got=%0d/%0d exp=3/6", retire_num, retire_tag[2]);
    end
    checks++;
    if (retire_value[1] !== 32'h55 || retire_value[2] !== 32'h66) begin
      errors++;
      $display("FAIL cr_dup got=%h,%h exp=55,66", retire_value[1], retire_value[2]);
    end
    checks++;
    if (retire_dest_idx[1] !== 5'd1 || retire_dest_idx[2] !== 5'd2
        || retire_has_dest[2:1] !== 2'b11) begin
      errors++;
      $display("FAIL cr_dest got=%0d,%0d,%b exp=1,2,11",
               retire_dest_idx[1], retire_dest_idx[2], retire_has_dest[2:1]);
    end
    tick();
    #1;
    checks++;
    if (rob_empty !== 1'b1) begin
      errors++;
      $display("FAIL cr_drained got=%b exp=1", rob_empty);
    end
  endtask

  task automatic test_full_wrap();
    int budget;
    int n;
    do_reset();
    fill_to(ROB_SIZE);
    #1;
    checks++;
    if (rob_full !== 1'b1 || dispatch_avail !== 2'd0) begin
      errors++;
      $display("FAIL full_flags got=%b/%0d exp=1/0", rob_full, dispatch_avail);
    end
    rand_dests(1);
    tick();
    #1;
    checks++;
    if (rob_full !== 1'b1 || rob_tail_out !== 5'd31) begin
      errors++;
      $display("FAIL full_drop got=%b/%0d exp=1/31", rob_full, rob_tail_out);
    end
    complete_num = 2'd3;
    for (int i = 0; i < 3; i++) begin
      CDB_tag_in[i]   = 5'(i);
      CDB_value_in[i] = $urandom;
    end
    tick();
    #1;
    checks++;
    if (retire_num !== 2'd3 || dispatch_avail !== 2'd0) begin
      errors++;
      $display("FAIL full_retire got=%0d/%0d exp=3/0", retire_num, dispatch_avail);
    end
    tick();
    rand_dests(3);
    #1;
    checks++;
    if (rob_tail_out !== 5'd2) begin
      errors++;
      $display("FAIL wrap_tail got=%0d exp=2", rob_tail_out);
    end
    tick();
    budget = 0;
    while (mq.size() > 0 && budget < 60) begin
      n = 0;
      foreach (mq[k]) begin
        if (!mq[k].done && n < 3) begin
          CDB_tag_in[n]   = 5'(mq[k].tag);
          CDB_value_in[n] = $urandom;
          n++;
        end
      end
      complete_num = 2'(n);
      #1;
      checks++;
      if (int'(retire_num) !== m_retn()
          || (m_retn() > 0 && int'(retire_tag[0]) !== mq[0].tag)) begin
        errors++;
        $display("FAIL wrap_drain got=%0d/%0d exp=%0d/%0d", retire_num,
                 retire_tag[0], m_retn(), (mq.size() > 0) ? mq[0].tag : 0);
      end
      tick();
      budget++;
    end
    #1;
    checks++;
    if (rob_empty !== 1'b1 || budget >= 60) begin
      errors++;
      $display("FAIL wrap_empty got=%b/%0d exp=1/<60", rob_empty, budget);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    fill_to(30);
    complete_num = 2'd3;
    for (int i = 0; i < 3; i++) begin
      CDB_tag_in[i]   = 5'(i);
      CDB_value_in[i] = $urandom;
    end
    tick();
    rand_dests(3);
    #1;
    checks++;
    if (retire_num !== 2'd3 || dispatch_avail !== 2'd2) begin
      errors++;
      $display("FAIL sim_drop got=%0d/%0d exp=3/2", retire_num, dispatch_avail);
    end
    tick();
    rand_dests(3);
    #1;
    checks++;
    if (dispatch_avail !== 2'd3 || rob_tail_out !== 5'd0) begin
      errors++;
      $display("FAIL sim_accept got=%0d/%0d exp=3/0", dispatch_avail, rob_tail_out);
    end
    tick();
    #1;
    checks++;
    if (rob_tail_out !== 5'd0) begin
      errors++;
      $display("FAIL sim_tail got=%0d exp=0", rob_tail_out);
    end
  endtask

  task automatic test_random();
    int av;
    int dn;
    int cn;
    int rn;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      av = m_avail();
      if ($urandom_range(39) == 0) dn = $urandom_range(3);
      else dn = $urandom_range(av);
      rand_dests(dn);
      cn = $urandom_range(3);
      complete_num = 2'(cn);
      for (int i = 0; i < 3; i++) begin
        if (mq.size() > 0 && $urandom_range(3) != 0)
          CDB_tag_in[i] = 5'(mq[$urandom_range(mq.size() - 1)].tag);
        else
          CDB_tag_in[i] = 5'($urandom_range(ROB_SIZE - 1));
        CDB_value_in[i] = $urandom;
      end
      #1;
      rn = m_retn();
      checks++;
      if (int'(retire_num) !== rn) begin
        errors++;
        $display("FAIL rnd_retire_num cyc=%0d got=%0d exp=%0d", cyc, retire_num, rn);
      end
      for (int s = 0; s < 3; s++) begin
        checks++;
        if (s < rn) begin
          if (int'(retire_tag[s]) !== mq[s].tag
              || int'(retire_dest_idx[s]) !== mq[s].dest
              || retire_has_dest[s] !== mq[s].hd
              || retire_value[s] !== mq[s].val) begin
            errors++;
            $display("FAIL rnd_slot%0d cyc=%0d got=%0d/%0d/%b/%h exp=%0d/%0d/%b/%h",
                     s, cyc, retire_tag[s], retire_dest_idx[s],
                     retire_has_dest[s], retire_value[s],
                     mq[s].tag, mq[s].dest, mq[s].hd, mq[s].val);
          end
        end else if (retire_tag[s] !== '0 || retire_dest_idx[s] !== '0
                     || retire_has_dest[s] !== 1'b0 || retire_value[s] !== '0) begin
          errors++;
          $display("FAIL rnd_unused%0d cyc=%0d got=%0d/%h exp=0/0",
                   s, cyc, retire_tag[s], retire_value[s]);
        end
      end
      checks++;
      if (int'(dispatch_avail) !== av
          || int'(rob_tail_out) !== (m_tail + dn + ROB_SIZE - 1) % ROB_SIZE) begin
        errors++;
        $display("FAIL rnd_disp cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                 dispatch_avail, rob_tail_out, av,
                 (m_tail + dn + ROB_SIZE - 1) % ROB_SIZE);
      end
      checks++;
      if (rob_empty !== (mq.size() == 0) || rob_full !== (mq.size() == ROB_SIZE)) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d got=%b/%b size=%0d", cyc,
                 rob_empty, rob_full, mq.size());
      end
      tick();
    end
  endtask

`ifdef ROB_SQUASH_EN
  task automatic test_squash();
    do_reset();
    fill_to(10);
    complete_num    = 2'd1;
    CDB_tag_in[0]   = 5'd0;
    CDB_value_in[0] = 32'h1;
    tick();
    squash       = 1'b1;
    rand_dests(2);
    complete_num = 2'd1;
    CDB_tag_in[0] = 5'd1;
    #1;
    checks++;
    if (retire_num !== 2'd0) begin
      errors++;
      $display("FAIL sq_retire got=%0d exp=0", retire_num);
    end
    tick();
    #1;
    checks++;
    if (rob_empty !== 1'b1 || rob_tail_out !== 5'd31) begin
      errors++;
      $display("FAIL sq_state got=%b/%0d exp=1/31", rob_empty, rob_tail_out);
    end
    rand_dests(1);
    #1;
    checks++;
    if (rob_tail_out !== 5'd0) begin
      errors++;
      $display("FAIL sq_tail got=%0d exp=0", rob_tail_out);
    end
    tick();
  endtask
`endif

  initial begin
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_dispatch();
    test_complete_retire();
    test_full_wrap();
    test_simultaneous();
    test_random();
`ifdef ROB_SQUASH_EN
    test_squash();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
